// File: rtl/uart_pkg.sv
// Shared UART definitions: newline constant and the sticky receive status
// record that CSR blocks also consume.
package uart_pkg;

   localparam logic [7:0] NEWLINE = 8'h0A;

   typedef struct packed {
      logic overrun;
      logic error_seen;
      logic break_seen;
   } uart_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for a pointer-based FIFO: synchronous write port and
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem #(
   parameter int Depth = 16,
   parameter int Width = 8,
   localparam int AW   = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [Width-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [Width-1:0] rd_data
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive queue behind uart_rx, with sticky status.
// Define UART_RX_FIFO_LINE_DETECT_EN to track queued newlines (line_available).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int Depth = 16,
   parameter int Width = 8,
   localparam int CW   = $clog2(Depth) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] rx_data,
   input  logic             rx_valid,
   input  logic             rx_error,
   input  logic             rx_break,
   output logic [Width-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             overrun,
   output logic             error_seen,
   output logic             break_seen,
   input  logic             clear_flags,
   output logic             line_available
);

   localparam int AW = $clog2(Depth);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   uart_status_t     status_q, status_d;
   logic [Width-1:0] mem_rd_data;
   logic             push, pop;

   // A push while full is dropped even if a pop frees a slot this cycle.
   assign push = rx_valid && !full_q;
   assign pop  = data_valid && data_ready;

   sync_fifo_mem #(
      .Depth (Depth),
      .Width (Width)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (rx_data),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(Depth));

      // Set beats clear when both land in the same cycle.
      status_d.overrun    = (status_q.overrun    && !clear_flags) || (rx_valid && full_q);
      status_d.error_seen = (status_q.error_seen && !clear_flags) || rx_error;
      status_d.break_seen = (status_q.break_seen && !clear_flags) || rx_break;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         status_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         status_q <= status_d;
      end
   end

   assign data_valid = (count_q != '0);
   assign data_out   = data_valid ? mem_rd_data : '0;
   assign count      = count_q;
   assign full       = full_q;
   assign overrun    = status_q.overrun;
   assign error_seen = status_q.error_seen;
   assign break_seen = status_q.break_seen;

`ifdef UART_RX_FIFO_LINE_DETECT_EN
   logic [CW-1:0] nl_count_q, nl_count_d;
   logic          line_q, line_d;
   logic          nl_in, nl_out;

   assign nl_in  = push && (rx_data == Width'(NEWLINE));
   assign nl_out = pop && (data_out == Width'(NEWLINE));

   always_comb begin
      nl_count_d = nl_count_q;
      case ({nl_in, nl_out})
         2'b10:   nl_count_d = nl_count_q + CW'(1);
         2'b01:   nl_count_d = nl_count_q - CW'(1);
         default: nl_count_d = nl_count_q;
      endcase
      line_d = (nl_count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nl_count_q <= '0;
         line_q     <= 1'b0;
      end else begin
         nl_count_q <= nl_count_d;
         line_q     <= line_d;
      end
   end

   assign line_available = line_q;
`else
   assign line_available = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected bytes are queued at push time and
// a negedge monitor compares every handshaked byte against that queue.
module tb_uart_rx_fifo;

   localparam int Depth = 16;
   localparam int Width = 8;
   localparam int CW    = $clog2(Depth) + 1;

`ifdef UART_RX_FIFO_LINE_DETECT_EN
   localparam logic LA_ON = 1'b1;
`else
   localparam logic LA_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [Width-1:0] rx_data;
   logic             rx_valid, rx_error, rx_break;
   logic [Width-1:0] data_out;
   logic             data_valid, data_ready;
   logic [CW-1:0]    count;
   logic             full, overrun, error_seen, break_seen;
   logic             clear_flags, line_available;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   uart_rx_fifo #(.Depth(Depth), .Width(Width)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_error       (rx_error),
      .rx_break       (rx_break),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .count          (count),
      .full           (full),
      .overrun        (overrun),
      .error_seen     (error_seen),
      .break_seen     (break_seen),
      .clear_flags    (clear_flags),
      .line_available (line_available)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Scoreboard monitor: the handshake seen here completes at the next posedge.
   always @(negedge clk) begin
      if (!rst && data_valid && data_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got %0h expected none", data_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               bad++;
               $display("FAIL pop_data: got %0h expected %0h", data_out, e);
            end else begin
               $display("ok   pop_data: %0h", data_out);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input bit accept);
      rx_data  = b;
      rx_valid = 1'b1;
      if (accept) exp_q.push_back(b);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      data_ready = 1'b1;
      for (int i = 0; i < budget && data_valid; i++) tick();
      data_ready = 1'b0;
      chk("drain_empty", {31'd0, data_valid}, 32'd0);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rx_data = '0; rx_valid = 0; rx_error = 0; rx_break = 0;
      data_ready = 0; clear_flags = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_full", full, 0);
      chk("rst_flags", {overrun, error_seen, break_seen}, 0);
      chk("rst_line", line_available, 0);

      // Hold off the consumer, queue "Hi\n", then drain in order.
      push(8'h48, 1); push(8'h69, 1); push(8'h0A, 1);
      chk("t1_count", count, 3);
      chk("t1_line", line_available, LA_ON);
      chk("t1_head", data_out, 8'h48);
      drain(10);
      chk("t1_line_after", line_available, 0);
      chk("t1_data_out_empty", data_out, 0);

      // Overfill: 16 accepted, 17th dropped.
      for (int i = 0; i < 16; i++) push(8'(i), 1);
      push(8'h10, 0);
      chk("t2_full", full, 1);
      chk("t2_count", count, 16);
      chk("t2_overrun", overrun, 1);
      data_ready = 1'b1; tick(); data_ready = 1'b0;
      chk("t2_full_after_pop", full, 0);
      chk("t2_count_after_pop", count, 15);

      // Refill, then push+pop while full: the push must be dropped.
      push(8'h20, 1);
      chk("t3_full", full, 1);
      rx_data = 8'hAA; rx_valid = 1'b1; data_ready = 1'b1;
      tick();
      rx_valid = 1'b0; data_ready = 1'b0;
      chk("t3_count", count, 15);
      chk("t3_overrun", overrun, 1);
      drain(40);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      chk("t3_overrun_cleared", overrun, 0);

      // Sticky error/break flags and set-beats-clear.
      rx_error = 1'b1; tick(); rx_error = 1'b0;
      chk("t4_error", {error_seen, break_seen}, 2'b10);
      rx_break = 1'b1; tick(); rx_break = 1'b0;
      chk("t4_both", {error_seen, break_seen}, 2'b11);
      chk("t4_no_enqueue", count, 0);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      chk("t4_cleared", {error_seen, break_seen}, 2'b00);
      clear_flags = 1'b1; rx_error = 1'b1; tick(); clear_flags = 1'b0; rx_error = 1'b0;
      chk("t4_set_wins", {error_seen, break_seen}, 2'b10);

      // Reset mid-operation discards contents and flags.
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1);
      chk("t5_count_pre", count, 5);
      rst = 1'b1; tick(); rst = 1'b0;
      exp_q.delete();
      chk("t5_count", count, 0);
      chk("t5_valid", data_valid, 0);
      chk("t5_flags", {overrun, error_seen, break_seen, line_available}, 0);
      push(8'h55, 1);
      chk("t5_readback", data_out, 8'h55);
      drain(5);

      // Consumer always ready: one-cycle visibility.
      data_ready = 1'b1;
      push(8'h3C, 1);
      chk("t6_valid", data_valid, 1);
      chk("t6_data", data_out, 8'h3C);
      tick();
      chk("t6_valid_gone", data_valid, 0);
      chk("t6_count", count, 0);
      data_ready = 1'b0;
      chk("t6_scoreboard_empty", exp_q.size(), 0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
